if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V core. It owns the program counter and a direct-mapped, one-word-per-line instruction cache. On a miss it fetches the word through a request/done handshake with the memory controller, and it presents pc/instruction pairs to the IF/ID pipeline register. It accepts branch redirects from EX and stalls from the central stall controller. It raises its own stall request while a miss is outstanding.

---
 rtl/if_stage.sv | 100 ++++++++++
 tb/tb_if_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage. Holds the PC and a direct-mapped, one-word-per-line
// instruction cache that refills through a req/done handshake on a miss.
module if_stage #(
    parameter int ADDR_WIDTH   = 17,
    parameter int ICACHE_LINES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [6:0]  stall,
    input  logic        br_flag,
    input  logic [31:0] br_target,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);
    localparam int IDX   = $clog2(ICACHE_LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state;
    logic [31:0]             pc;
    logic [ICACHE_LINES-1:0] valid;
    logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
    logic [31:0]             data_mem [ICACHE_LINES];

    logic [IDX-1:0]   idx;
    logic [IDX-1:0]   fill_idx;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             fill;
    logic             unused_stall;

    assign idx      = pc[IDX+1:2];
    assign tag      = pc[ADDR_WIDTH-1:IDX+2];
    assign fill_idx = mem_addr[IDX+1:2];
    assign fill_tag = mem_addr[ADDR_WIDTH-1:IDX+2];
    assign hit      = valid[idx] && (tag_mem[idx] == tag);
    assign fill     = rdy && (state == WAIT) && mem_done;

    // Only stall[0] concerns fetch; the other bits belong to later stages.
    assign unused_stall = ^stall[6:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= 32'd0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'd0;
            valid       <= '0;
            if_pc       <= 32'd0;
            if_inst     <= 32'd0;
            stallreq_if <= 1'b0;
        end else if (rdy) begin
            if_pc   <= pc;
            if_inst <= (state == IDLE && hit && !br_flag) ? data_mem[idx] : 32'd0;
            case (state)
                IDLE: begin
                    if (!hit) begin
                        mem_req     <= 1'b1;
                        mem_addr    <= pc;
                        state       <= WAIT;
                        stallreq_if <= 1'b1;
                    end else begin
                        stallreq_if <= 1'b0;
                    end
                end
                WAIT: begin
                    // A redirect never aborts the fill; the line lands at the latched address.
                    if (mem_done) begin
                        valid[fill_idx] <= 1'b1;
                        mem_req         <= 1'b0;
                        state           <= IDLE;
                        stallreq_if     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (br_flag) begin
                pc <= br_target;
            end else if (state == IDLE && hit && !stall[0]) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the fetch stage.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [6:0]  stall;
    logic        br_flag;
    logic [31:0] br_target;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage #(.ADDR_WIDTH(17), .ICACHE_LINES(128)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
        .br_flag(br_flag), .br_target(br_target),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
    );

    // Reference model: cache as a map line -> (word-address, instruction).
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    bit          m_wait;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    bit          e_stallreq;
    bit          line_ok   [128];
    logic [31:0] line_blk  [128];
    logic [31:0] line_word [128];
    int          lat;
    int          cnt;
    bit          rand_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h13;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_req_addr = 0; m_wait = 0;
        e_pc = 0; e_inst = 0; e_stallreq = 0;
        for (int i = 0; i < 128; i++) line_ok[i] = 0;
        cnt = 0;
    endtask

    // Memory responder plus model update, then one clock edge.
    task automatic tick();
        int          idx;
        int          fidx;
        logic [31:0] blk;
        bit          hit;
        mem_done  = 1'b0;
        mem_rdata = 32'd0;
        if (m_wait && rdy) begin
            cnt++;
            if (cnt >= lat) begin
                mem_done  = 1'b1;
                mem_rdata = mem_word(m_req_addr);
                cnt = 0;
                if (rand_lat) lat = $urandom_range(1, 4);
            end
        end
        if (rdy) begin
            idx = int'((m_pc >> 2) % 32'd128);
            blk = (m_pc % 32'h20000) >> 2;
            hit = !m_wait && line_ok[idx] && (line_blk[idx] == blk);
            e_pc   = m_pc;
            e_inst = (hit && !br_flag) ? line_word[idx] : 32'd0;
            if (m_wait) begin
                if (mem_done) begin
                    fidx = int'((m_req_addr >> 2) % 32'd128);
                    line_ok[fidx]   = 1;
                    line_blk[fidx]  = (m_req_addr % 32'h20000) >> 2;
                    line_word[fidx] = mem_rdata;
                    m_wait = 0;
                end
            end else if (!hit) begin
                m_wait     = 1;
                m_req_addr = m_pc;
            end
            e_stallreq = m_wait;
            if (br_flag) m_pc = br_target;
            else if (hit && !stall[0]) m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        mem_done = 1'b0;
    endtask

    task automatic branch(input logic [31:0] target);
        br_flag = 1'b1;
        br_target = target;
        tick();
        br_flag = 1'b0;
    endtask

    task automatic run_until_idle(input string name);
        int n;
        n = 0;
        while (m_wait && n < 40) begin
            tick();
            n++;
        end
        if (m_wait) begin
            checks++; errors++;
            $display("[TB] FAIL %s_timeout: fill still pending after %0d cycles, required done", name, n);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; rdy = 1'b1; stall = 7'd0; br_flag = 1'b0; br_target = 32'd0;
        mem_done = 1'b0; mem_rdata = 32'd0;
        lat = 3; rand_lat = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks += 5;
        if (if_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0", if_pc); end
        if (if_inst !== 32'd0) begin errors++; $display("[TB] FAIL reset_inst: got %h want 0", if_inst); end
        if (stallreq_if !== 1'b0) begin errors++; $display("[TB] FAIL reset_stallreq: got %b want 0", stallreq_if); end
        if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", mem_req); end
        if (mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", mem_addr); end
    endtask

    task automatic test_cold_start();
        tick();
        checks += 4;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL cold_req: got %b want 1", mem_req); end
        if (mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL cold_addr: got %h want 0", mem_addr); end
        if (stallreq_if !== 1'b1) begin errors++; $display("[TB] FAIL cold_stallreq: got %b want 1", stallreq_if); end
        if (if_inst !== 32'd0) begin errors++; $display("[TB] FAIL cold_bubble: got %h want 0", if_inst); end
        tick(); tick();
        checks++;
        if (stallreq_if !== 1'b1) begin errors++; $display("[TB] FAIL cold_stall_hold: got %b want 1", stallreq_if); end
        tick();
        checks += 2;
        if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL cold_req_drop: got %b want 0", mem_req); end
        if (stallreq_if !== 1'b0) begin errors++; $display("[TB] FAIL cold_stall_drop: got %b want 0", stallreq_if); end
        tick();
        checks += 2;
        if (if_pc !== 32'd0) begin errors++; $display("[TB] FAIL cold_pc: got %h want 0", if_pc); end
        if (if_inst !== 32'h13) begin errors++; $display("[TB] FAIL cold_inst: got %h want 00000013", if_inst); end
        tick();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL cold_next_req: got %b want 1", mem_req); end
        if (mem_addr !== 32'h4) begin errors++; $display("[TB] FAIL cold_next_addr: got %h want 4", mem_addr); end
    endtask

    task automatic test_warm_loop();
        int n;
        n = 0;
        while (!(m_pc == 32'hC && !m_wait && line_ok[3] && line_blk[3] == 32'd3) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 60) begin errors++; $display("[TB] FAIL warm_preload: pc %h not ready after %0d cycles", m_pc, n); end
        branch(32'h0);
        checks += 2;
        if (if_pc !== 32'hC) begin errors++; $display("[TB] FAIL warm_br_pc: got %h want c", if_pc); end
        if (if_inst !== 32'd0) begin errors++; $display("[TB] FAIL warm_br_bubble: got %h want 0", if_inst); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 4;
            if (if_pc !== 32'(4 * i)) begin errors++; $display("[TB] FAIL warm_pc%0d: got %h want %h", i, if_pc, 4 * i); end
            if (if_inst !== mem_word(32'(4 * i))) begin errors++; $display("[TB] FAIL warm_inst%0d: got %h want %h", i, if_inst, mem_word(32'(4 * i))); end
            if (stallreq_if !== 1'b0) begin errors++; $display("[TB] FAIL warm_stall%0d: got %b want 0", i, stallreq_if); end
            if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL warm_req%0d: got %b want 0", i, mem_req); end
        end
    endtask

    task automatic test_stall_hold();
        stall = {6'($urandom_range(0, 63)), 1'b1};
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 2;
            if (if_pc !== 32'hC) begin errors++; $display("[TB] FAIL hold_pc%0d: got %h want c", i, if_pc); end
            if (if_inst !== mem_word(32'hC)) begin errors++; $display("[TB] FAIL hold_inst%0d: got %h want %h", i, if_inst, mem_word(32'hC)); end
        end
        stall = 7'd0;
        tick();
        checks++;
        if (if_pc !== 32'hC) begin errors++; $display("[TB] FAIL release_pc: got %h want c", if_pc); end
        tick();
        checks += 3;
        if (if_pc !== 32'h10) begin errors++; $display("[TB] FAIL resume_pc: got %h want 10", if_pc); end
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL resume_req: got %b want 1", mem_req); end
        if (mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL resume_addr: got %h want 10", mem_addr); end
    endtask

    task automatic test_branch_wait();
        branch(32'h40);
        checks += 3;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL bw_req_held: got %b want 1", mem_req); end
        if (mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL bw_addr_held: got %h want 10", mem_addr); end
        if (if_inst !== 32'd0) begin errors++; $display("[TB] FAIL bw_bubble: got %h want 0", if_inst); end
        run_until_idle("bw_fill");
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL bw_req_drop: got %b want 0", mem_req); end
        tick();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL bw_new_req: got %b want 1", mem_req); end
        if (mem_addr !== 32'h40) begin errors++; $display("[TB] FAIL bw_new_addr: got %h want 40", mem_addr); end
        run_until_idle("bw_fill40");
        branch(32'h10);
        tick();
        checks += 3;
        if (if_pc !== 32'h10) begin errors++; $display("[TB] FAIL bw_line_pc: got %h want 10", if_pc); end
        if (if_inst !== mem_word(32'h10)) begin errors++; $display("[TB] FAIL bw_line_inst: got %h want %h", if_inst, mem_word(32'h10)); end
        if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL bw_line_req: got %b want 0", mem_req); end
    endtask

    task automatic test_alias();
        reset_dut();
        tick();
        run_until_idle("alias_fill0");
        branch(32'h200);
        tick();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL alias_req200: got %b want 1", mem_req); end
        if (mem_addr !== 32'h200) begin errors++; $display("[TB] FAIL alias_addr200: got %h want 200", mem_addr); end
        run_until_idle("alias_fill200");
        branch(32'h0);
        tick();
        checks += 3;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL alias_evict_req: got %b want 1", mem_req); end
        if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL alias_evict_addr: got %h want 0", mem_addr); end
        if (if_inst !== 32'd0) begin errors++; $display("[TB] FAIL alias_evict_inst: got %h want 0", if_inst); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        tick();
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre_req: got %b want 1", mem_req); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL ar_req: got %b want 0", mem_req); end
        if (if_pc !== 32'd0) begin errors++; $display("[TB] FAIL ar_pc: got %h want 0", if_pc); end
        if (stallreq_if !== 1'b0) begin errors++; $display("[TB] FAIL ar_stallreq: got %b want 0", stallreq_if); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL ar_refetch_req: got %b want 1", mem_req); end
        if (mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL ar_refetch_addr: got %h want 0", mem_addr); end
    endtask

    task automatic test_random();
        reset_dut();
        rand_lat = 1;
        lat = $urandom_range(1, 4);
        for (int c = 0; c < 600; c++) begin
            rdy   = ($urandom_range(0, 7) != 0);
            stall = 7'($urandom);
            stall[0] = ($urandom_range(0, 3) == 0);
            br_flag = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0, 1: br_target = 32'($urandom_range(0, 31)) << 2;
                2:    br_target = 32'h200 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 1)) << 17);
                default: br_target = 32'hFFFFFFF0 + (32'($urandom_range(0, 3)) << 2);
            endcase
            tick();
            checks += 5;
            if (if_pc !== e_pc) begin errors++; $display("[TB] FAIL rnd_pc cycle %0d: got %h want %h", c, if_pc, e_pc); end
            if (if_inst !== e_inst) begin errors++; $display("[TB] FAIL rnd_inst cycle %0d: got %h want %h", c, if_inst, e_inst); end
            if (stallreq_if !== e_stallreq) begin errors++; $display("[TB] FAIL rnd_stallreq cycle %0d: got %b want %b", c, stallreq_if, e_stallreq); end
            if (mem_req !== m_wait) begin errors++; $display("[TB] FAIL rnd_req cycle %0d: got %b want %b", c, mem_req, m_wait); end
            if (mem_addr !== m_req_addr) begin errors++; $display("[TB] FAIL rnd_addr cycle %0d: got %h want %h", c, mem_addr, m_req_addr); end
        end
        br_flag = 1'b0;
        rdy = 1'b1;
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_warm_loop();
        test_stall_hold();
        test_branch_wait();
        test_alias();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
